// File: rtl/fetch_predict_stage.sv
// IF stage: PC register, next-PC selection and IF/ID pipeline register.
// Define BRANCH_PRED_EN for a direct-mapped BTB with 2-bit counters; otherwise static not-taken.
module fetch_predict_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IDX_W    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        PredTakenD,
   output logic [31:0] PredTargetD,
   input  logic        BranchE,
   input  logic        TakenE,
   input  logic [31:0] PCE,
   input  logic [31:0] PCTargetE,
   input  logic [31:0] PCPlus4E,
   input  logic        PredTakenE,
   input  logic [31:0] PredTargetE,
   output logic        MispredictE
);
   localparam int          ENTRIES = 1 << IDX_W;
   localparam int          TAG_W   = 30 - IDX_W;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic [31:0] pc_plus4;
   logic [31:0] pc_next;
   logic        predict;
   logic [31:0] pred_target;

   assign pc_plus4 = PCF + 32'd4;

`ifdef BRANCH_PRED_EN
   logic [ENTRIES-1:0] valid;
   logic [1:0]         ctr [ENTRIES];
   logic [TAG_W-1:0]   tag [ENTRIES];
   logic [31:0]        tgt [ENTRIES];
   logic [IDX_W-1:0]   look_idx;
   logic [IDX_W-1:0]   upd_idx;
   logic [1:0]         unused_pce_bits;

   assign look_idx        = PCF[IDX_W+1:2];
   assign upd_idx         = PCE[IDX_W+1:2];
   assign unused_pce_bits = PCE[1:0];
   assign predict     = valid[look_idx] && (tag[look_idx] == PCF[31:IDX_W+2]) && ctr[look_idx][1];
   assign pred_target = tgt[look_idx];
   assign MispredictE = rst && BranchE &&
                        ((TakenE != PredTakenE) ||
                         (TakenE && PredTakenE && (PredTargetE != PCTargetE)));

   // Counters saturate at both ends; not-taken outcomes never invalidate an entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr[i] <= 2'b01;
         end
      end else if (BranchE) begin
         if (TakenE) begin
            valid[upd_idx] <= 1'b1;
            if (ctr[upd_idx] != 2'b11) begin
               ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
            end
         end else if (ctr[upd_idx] != 2'b00) begin
            ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && BranchE && TakenE) begin
         tag[upd_idx] <= PCE[31:IDX_W+2];
         tgt[upd_idx] <= PCTargetE;
      end
   end
`else
   logic unused_pred_inputs;

   assign unused_pred_inputs = ^{PCE, PredTakenE, PredTargetE};
   assign predict            = 1'b0;
   assign pred_target        = 32'h0000_0000;
   assign MispredictE        = rst && BranchE && TakenE;
`endif

   // A resolved mispredict must redirect even when fetch is stalled.
   always_comb begin
      pc_next = pc_plus4;
      if (MispredictE) begin
         pc_next = TakenE ? PCTargetE : PCPlus4E;
      end else if (StallF) begin
         pc_next = PCF;
      end else if (predict) begin
         pc_next = pred_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         PCF <= RESET_PC;
      end else begin
         PCF <= pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || FlushD) begin
         InstrD      <= NOP;
         PCD         <= 32'h0000_0000;
         PCPlus4D    <= 32'h0000_0000;
         PredTakenD  <= 1'b0;
         PredTargetD <= 32'h0000_0000;
      end else if (!StallD) begin
         InstrD      <= InstrF;
         PCD         <= PCF;
         PCPlus4D    <= pc_plus4;
         PredTakenD  <= predict;
         PredTargetD <= pred_target;
      end
   end
endmodule

// File: tb/tb_fetch_predict_stage.sv
// Self-checking bench for fetch_predict_stage: directed vector table plus randomized run
// against a behavioural model; follows BRANCH_PRED_EN the same way the design does.
module tb_fetch_predict_stage;
`ifdef BRANCH_PRED_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif
   localparam int          ENTRIES = 16;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, StallF, StallD, FlushD;
   logic [31:0] InstrF, PCF, InstrD, PCD, PCPlus4D, PredTargetD;
   logic        PredTakenD;
   logic        BranchE, TakenE, PredTakenE, MispredictE;
   logic [31:0] PCE, PCTargetE, PCPlus4E, PredTargetE;

   int unsigned compared = 0;
   int unsigned failed   = 0;

   typedef struct {
      logic        rst, stallf, stalld, flushd, branche, takene, predtakene;
      logic [31:0] pce, pctargete, pcplus4e, predtargete;
      logic        exp_mis;
      logic [31:0] exp_pcf;
      logic        exp_bub;
      logic [31:0] exp_pcd;
      logic        exp_ptk;
      logic [31:0] exp_ptg;
   } vec_t;

   vec_t tv [16];

   logic [31:0] m_pcf, m_pcd, m_ptg;
   logic        m_bub, m_ptk;
   bit          m_valid [ENTRIES];
   logic [31:0] m_tag [ENTRIES];
   logic [31:0] m_tgt [ENTRIES];
   int          m_ctr [ENTRIES];

   fetch_predict_stage dut (
      .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .PredTakenD(PredTakenD), .PredTargetD(PredTargetD), .BranchE(BranchE),
      .TakenE(TakenE), .PCE(PCE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
      .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE)
   );

   // Instruction memory stand-in: every word encodes its own address.
   assign InstrF = {16'hC0DE, PCF[15:0]};

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, sf, sd, fd, br, tk, ptke,
                               input logic [31:0] pce, tgte, ptge,
                               input logic emis, input logic [31:0] epcf,
                               input logic ebub, input logic [31:0] epcd,
                               input logic eptk, input logic [31:0] eptg);
      vec_t v;
      v.rst = r; v.stallf = sf; v.stalld = sd; v.flushd = fd;
      v.branche = br; v.takene = tk; v.predtakene = ptke;
      v.pce = pce; v.pctargete = tgte; v.pcplus4e = pce + 32'd4; v.predtargete = ptge;
      v.exp_mis = emis; v.exp_pcf = epcf; v.exp_bub = ebub; v.exp_pcd = epcd;
      v.exp_ptk = eptk; v.exp_ptg = eptg;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst = v.rst; StallF = v.stallf; StallD = v.stalld; FlushD = v.flushd;
      BranchE = v.branche; TakenE = v.takene; PredTakenE = v.predtakene;
      PCE = v.pce; PCTargetE = v.pctargete; PCPlus4E = v.pcplus4e; PredTargetE = v.predtargete;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Registered outputs: PredTargetD is only meaningful for a bubble or a taken prediction.
   task automatic checkRegs(input logic [31:0] epcf, input logic ebub, input logic [31:0] epcd,
                            input logic eptk, input logic [31:0] eptg);
      checkOutput("PCF", PCF, epcf);
      checkOutput("InstrD", InstrD, ebub ? NOP : {16'hC0DE, epcd[15:0]});
      checkOutput("PCD", PCD, ebub ? 32'h0 : epcd);
      checkOutput("PCPlus4D", PCPlus4D, ebub ? 32'h0 : epcd + 32'd4);
      checkOutput("PredTakenD", 32'(PredTakenD), ebub ? 32'h0 : 32'(eptk));
      if (ebub || eptk || !PRED_EN) begin
         checkOutput("PredTargetD", PredTargetD, ebub ? 32'h0 : eptg);
      end
   endtask

   task automatic modelStep(input vec_t v, output logic mis);
      int          idx;
      logic        pred;
      logic [31:0] ptgt;
      logic [31:0] npc;
      idx  = int'((m_pcf >> 2) % ENTRIES);
      pred = PRED_EN && m_valid[idx] && (m_tag[idx] == (m_pcf >> 6)) && (m_ctr[idx] >= 2);
      ptgt = PRED_EN ? m_tgt[idx] : 32'h0;
      if (PRED_EN) begin
         mis = v.branche && ((v.takene != v.predtakene) ||
               (v.takene && v.predtakene && v.predtargete != v.pctargete));
      end else begin
         mis = v.branche && v.takene;
      end
      mis = mis && v.rst;

      if (!v.rst)          npc = 32'h0;
      else if (mis)        npc = v.takene ? v.pctargete : v.pcplus4e;
      else if (v.stallf)   npc = m_pcf;
      else if (pred)       npc = ptgt;
      else                 npc = m_pcf + 32'd4;

      if (!v.rst || v.flushd) begin
         m_bub = 1'b1; m_pcd = 32'h0; m_ptk = 1'b0; m_ptg = 32'h0;
      end else if (!v.stalld) begin
         m_bub = 1'b0; m_pcd = m_pcf; m_ptk = pred; m_ptg = ptgt;
      end

      if (!v.rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
         end
      end else if (v.branche) begin
         idx = int'((v.pce >> 2) % ENTRIES);
         if (v.takene) begin
            m_ctr[idx]   = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = v.pce >> 6;
            m_tgt[idx]   = v.pctargete;
         end else begin
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
         end
      end
      m_pcf = npc;
   endtask

   initial begin
      vec_t r;
      logic exp_mis;

      tv[0]  = mk(0,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,  0, 32'h0, 1, 32'h0, 0, 32'h0);
      tv[1]  = mk(0,0,0,0, 1,1,0, 32'h10, 32'h40, 32'h0,  0, 32'h0, 1, 32'h0, 0, 32'h0);
      tv[2]  = mk(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,  0, 32'h4, 0, 32'h0, 0, 32'h0);
      tv[3]  = mk(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,  0, 32'h8, 0, 32'h4, 0, 32'h0);
      tv[4]  = mk(1,1,1,0, 0,0,0, 32'h0,  32'h0,  32'h0,  0, 32'h8, 0, 32'h4, 0, 32'h0);
      tv[5]  = mk(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,  0, 32'hC, 0, 32'h8, 0, 32'h0);
      tv[6]  = mk(1,1,0,1, 1,1,0, 32'h10, 32'h40, 32'h0,  1, 32'h40, 1, 32'h0, 0, 32'h0);
      tv[7]  = mk(1,0,0,1, 1,1,0, 32'h10, 32'h40, 32'h0,  1, 32'h40, 1, 32'h0, 0, 32'h0);
      tv[8]  = mk(1,0,0,1, 1,1,0, 32'h80, 32'h10, 32'h0,  1, 32'h10, 1, 32'h0, 0, 32'h0);
      tv[9]  = mk(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,  0, PRED_EN ? 32'h40 : 32'h14,
                  0, 32'h10, PRED_EN, PRED_EN ? 32'h40 : 32'h0);
      tv[10] = mk(1,0,0,1, 1,0,1, 32'h10, 32'h40, 32'h40, PRED_EN, PRED_EN ? 32'h14 : 32'h18,
                  1, 32'h0, 0, 32'h0);
      tv[11] = mk(1,0,0,1, 1,1,0, 32'h80, 32'h10, 32'h0,  1, 32'h10, 1, 32'h0, 0, 32'h0);
      tv[12] = tv[9];
      tv[13] = mk(1,0,1,1, 0,0,0, 32'h0,  32'h0,  32'h0,  0, PRED_EN ? 32'h44 : 32'h18,
                  1, 32'h0, 0, 32'h0);
      tv[14] = mk(1,0,1,0, 0,0,0, 32'h0,  32'h0,  32'h0,  0, PRED_EN ? 32'h48 : 32'h1C,
                  1, 32'h0, 0, 32'h0);
      tv[15] = mk(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,  0, PRED_EN ? 32'h4C : 32'h20,
                  0, PRED_EN ? 32'h48 : 32'h1C, 0, 32'h0);

      applyStimulus(tv[0]);
      @(posedge clk);
      #1;
      $display("[TB] directed vectors (predictor %0s)", PRED_EN ? "on" : "off");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(tv[i]);
         #2;
         checkOutput($sformatf("MispredictE[v%0d]", i), 32'(MispredictE), 32'(tv[i].exp_mis));
         @(posedge clk);
         #1;
         checkRegs(tv[i].exp_pcf, tv[i].exp_bub, tv[i].exp_pcd, tv[i].exp_ptk, tv[i].exp_ptg);
      end

      $display("[TB] randomized run against reference model");
      for (int c = 0; c < 3000; c++) begin
         r.rst         = (c == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
         r.stallf      = ($urandom_range(0, 4) == 0);
         r.stalld      = ($urandom_range(0, 4) == 0);
         r.flushd      = ($urandom_range(0, 7) == 0);
         r.branche     = ($urandom_range(0, 2) == 0);
         r.takene      = ($urandom_range(0, 1) == 1);
         r.predtakene  = ($urandom_range(0, 1) == 1);
         r.pce         = 32'($urandom_range(0, 63)) << 2;
         r.pctargete   = 32'($urandom_range(0, 63)) << 2;
         r.pcplus4e    = r.pce + 32'd4;
         r.predtargete = ($urandom_range(0, 1) == 1) ? r.pctargete : 32'($urandom_range(0, 63)) << 2;
         applyStimulus(r);
         #2;
         modelStep(r, exp_mis);
         checkOutput("MispredictE", 32'(MispredictE), 32'(exp_mis));
         @(posedge clk);
         #1;
         checkRegs(m_pcf, m_bub, m_pcd, m_ptk, m_ptg);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
